sm4_stream_bridge: RTL and testbench
====================================

# sm4_stream_bridge

Host-side bridge that wraps the SM4 pipeline with valid/ready streams on both ends. It issues blocks into the core's non-stallable `DAT_i`/`DAT_VALID_i` port and collects the core's `DAT_o`/`DAT_READY_o` result pulses into an output FIFO. Issue is credit-gated so every in-flight result is guaranteed a FIFO slot. It sits between the system bus logic and `sm4_toplevel`.

## Interface
Parameters:
- `DEPTH`, default 8: result FIFO entries. Must be a power of two, at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the in-flight counter and the level counter.

Ports:
- `CLK_i` input 1: single clock. All logic is on the rising edge.
- `RST_i` input 1: synchronous, active-high reset.
- `KEY_READY_i` input 1: round keys are valid (core key-expansion done, or fixed keys).
- `S_DAT_i` input 128: plaintext/ciphertext block from the host.
- `S_VALID_i` input 1: host block valid.
- `S_READY_o` output 1: bridge accepts the block this cycle.
- `CORE_DAT_o` output 128: to core `DAT_i`.
- `CORE_VALID_o` output 1: to core `DAT_VALID_i`. Single-cycle pulse per block.
- `CORE_DAT_i` input 128: from core `DAT_o`.
- `CORE_READY_i` input 1: from core `DAT_READY_o`. Single-cycle pulse per result.
- `M_DAT_o` output 128: result block to downstream.
- `M_VALID_o` output 1: result valid.
- `M_READY_i` input 1: downstream accepts.
- `LEVEL_o` output CW: current FIFO occupancy.
- `ERR_o` output 1: sticky protocol error (see Configuration).

## Operation
- **Accept:** when `S_VALID_i & S_READY_o`, register `S_DAT_i` into `CORE_DAT_o` and assert `CORE_VALID_o` for exactly one cycle. Otherwise `CORE_VALID_o` is 0 and `CORE_DAT_o` holds its last value.
- **Credit rule:** `S_READY_o = ~RST_i & KEY_READY_i & ((inflight + LEVEL_o) < DEPTH)`.
  - Combinational from registered state only, so it never depends on `S_VALID_i`.
- **inflight** (CW bits):
  - Increments on accept; decrements on `CORE_READY_i`.
  - Both in the same cycle leave it unchanged.
- **FIFO push:** on `CORE_READY_i`, `CORE_DAT_i` is written at the write pointer.
- **FIFO pop:** on `M_VALID_o & M_READY_i`.
- **Simultaneous push and pop:** allowed at any level, including full, where the pop frees the slot in the same cycle. `LEVEL_o` is unchanged.
- **Pointers:** `$clog2(DEPTH)` bits, wrapping naturally from `DEPTH-1` to 0. `LEVEL_o` ranges 0..DEPTH.
- **Ordering:** the core is in-order, so results leave in exactly host issue order.
- **Key not ready:**
  - `KEY_READY_i` low blocks new accepts.
  - Already-issued blocks still complete and drain.
  - `KEY_READY_i` falling mid-stream does not flush anything.
- **Reset:**
  - Clears pointers, `LEVEL_o`, `inflight`, and `ERR_o`.
  - `CORE_VALID_o`=0, `M_VALID_o`=0, `S_READY_o`=0, `CORE_DAT_o`=0, `M_DAT_o`=0.
  - Results arriving during reset, or after reset for blocks issued before it, are protocol errors. The system must also reset the core with the bridge.

## Timing
- **Host accept to core:** accept in cycle t gives `CORE_VALID_o` high in cycle t+1.
- **Core result to downstream:** `CORE_READY_i` in cycle u gives `M_VALID_o` high in cycle u+1 with `M_DAT_o` valid. The FIFO output is registered with no fall-through.
- **End-to-end latency:** core latency + 2 cycles.
- **Throughput:** one block per cycle sustained while `M_READY_i` stays high and `DEPTH` ≥ core latency + 2. A smaller `DEPTH` throttles issue; it never loses data.
- **Output stability:** `M_VALID_o`/`M_DAT_o` stay stable until popped.
- **Back-pressure:** downstream stalls stop issue only via credit. Blocks already in flight always land in reserved FIFO slots.

## Configuration
- **Macro:** `SM4_BRIDGE_ERRCHK_EN`.
- **Defined:**
  - `ERR_o` sets (sticky until reset) on `CORE_READY_i` with `inflight==0`, or on push with `LEVEL_o==DEPTH` and no simultaneous pop.
  - The offending result is dropped; `inflight` does not underflow and the FIFO is not written.
- **Not defined:**
  - `ERR_o` is tied 0 and the checks are not built.
  - An unsolicited result is still dropped when the FIFO is full.
  - `inflight` saturates at 0.

## Test plan
- **Single block:**
  - Stimulus: reset, `KEY_READY_i`=1, one block `0x0123456789abcdeffedcba9876543210`, core model loops back after 32 cycles.
  - Required: `CORE_VALID_o` one cycle after accept; `M_VALID_o` 33 cycles after `CORE_VALID_o`; `M_DAT_o` equals the model output; `LEVEL_o` returns 0 after the pop.
- **Streaming:**
  - Stimulus: 100 back-to-back blocks, `M_READY_i`=1, `DEPTH`=64, latency 32.
  - Required: zero stall cycles on `S_READY_o`; all 100 results in order.
- **Back-pressure:**
  - Stimulus: `DEPTH`=8, `M_READY_i`=0, host always valid.
  - Required: exactly 8 accepts, then `S_READY_o`=0; `LEVEL_o` reaches 8; releasing `M_READY_i` drains 8 in order and resumes issue.
- **Key gating:**
  - Stimulus: `KEY_READY_i`=0 with `S_VALID_i`=1.
  - Required: no `CORE_VALID_o` pulses. When `KEY_READY_i` rises in cycle k, the first accept is in cycle k.
- **Full-FIFO simultaneous push/pop:**
  - Stimulus: FIFO full, then a cycle with `CORE_READY_i` and pop together.
  - Required: `LEVEL_o` stays at `DEPTH`; no `ERR_o`; correct wrap-around ordering over 3×DEPTH blocks.
- **Error check (macro defined):**
  - Stimulus: inject `CORE_READY_i` with `inflight`=0.
  - Required: `ERR_o`=1 next cycle and held; `LEVEL_o` unchanged; `RST_i` clears `ERR_o`.

Source files
------------

// File: rtl/sm4_stream_bridge_if.sv
// sm4_stream_bridge_if: host, core and downstream stream signals of the SM4 bridge.
// slave is the bridge side; master is the surrounding system or testbench.
interface sm4_stream_bridge_if #(
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH) + 1
);
    logic          KEY_READY_i;
    logic [127:0]  S_DAT_i;
    logic          S_VALID_i;
    logic          S_READY_o;
    logic [127:0]  CORE_DAT_o;
    logic          CORE_VALID_o;
    logic [127:0]  CORE_DAT_i;
    logic          CORE_READY_i;
    logic [127:0]  M_DAT_o;
    logic          M_VALID_o;
    logic          M_READY_i;
    logic [CW-1:0] LEVEL_o;
    logic          ERR_o;
    modport slave (
        input  KEY_READY_i, S_DAT_i, S_VALID_i, CORE_DAT_i, CORE_READY_i, M_READY_i,
        output S_READY_o, CORE_DAT_o, CORE_VALID_o, M_DAT_o, M_VALID_o, LEVEL_o, ERR_o
    );
    modport master (
        output KEY_READY_i, S_DAT_i, S_VALID_i, CORE_DAT_i, CORE_READY_i, M_READY_i,
        input  S_READY_o, CORE_DAT_o, CORE_VALID_o, M_DAT_o, M_VALID_o, LEVEL_o, ERR_o
    );
endinterface

// File: rtl/sm4_stream_bridge.sv
// sm4_stream_bridge: credit-gated issue into the non-stallable SM4 core with a result FIFO.
// Define SM4_BRIDGE_ERRCHK_EN to build the sticky protocol-error checks on ERR_o.
module sm4_stream_bridge #(
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input logic CLK_i,
    input logic RST_i,
    sm4_stream_bridge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] level, inflight;
    logic [CW:0]   used;
    logic [127:0]  mem [DEPTH];
    logic [127:0]  core_dat;
    logic          core_valid, acc, pop, push, full, dec;
    // every issued block owns a FIFO slot until it is popped
    assign used = {1'b0, inflight} + {1'b0, level};
    assign bus.S_READY_o = ~RST_i & bus.KEY_READY_i & (used < (CW+1)'(DEPTH));
    assign acc = bus.S_VALID_i & bus.S_READY_o;
    assign full = level == CW'(DEPTH);
    assign bus.M_VALID_o = level != '0;
    assign pop = bus.M_VALID_o & bus.M_READY_i;
    assign dec = bus.CORE_READY_i & (inflight != '0);
`ifdef SM4_BRIDGE_ERRCHK_EN
    logic err;
    // unsolicited or overflowing results are dropped, never stored
    assign push = dec & (~full | pop);
    always_ff @(posedge CLK_i) begin
        err <= RST_i ? 1'b0 : err | (bus.CORE_READY_i & ~push);
    end
    assign bus.ERR_o = err;
`else
    assign push = bus.CORE_READY_i & (~full | pop);
    assign bus.ERR_o = 1'b0;
`endif
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            wp         <= '0;
            rp         <= '0;
            level      <= '0;
            inflight   <= '0;
            core_valid <= 1'b0;
            core_dat   <= '0;
        end else begin
            inflight   <= inflight + CW'(acc) - CW'(dec);
            level      <= level + CW'(push) - CW'(pop);
            wp         <= push ? wp + AW'(1) : wp;
            rp         <= pop ? rp + AW'(1) : rp;
            core_valid <= acc;
            core_dat   <= acc ? bus.S_DAT_i : core_dat;
        end
    end
    always_ff @(posedge CLK_i) begin
        if (push) mem[wp] <= bus.CORE_DAT_i;
    end
    assign bus.CORE_VALID_o = core_valid;
    assign bus.CORE_DAT_o = core_dat;
    assign bus.M_DAT_o = bus.M_VALID_o ? mem[rp] : '0;
    assign bus.LEVEL_o = level;
endmodule

// File: tb/tb_sm4_stream_bridge.sv
// tb_sm4_stream_bridge: randomized bench with a loop-back core model and an
// accept/pop scoreboard; the bridge under test uses an 8-entry FIFO.
module tb_sm4_stream_bridge;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct {
        int           due;
        logic [127:0] d;
    } pend_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 4;
    logic inj = 1'b0;
    logic [127:0] inj_dat = '0;
    logic model_ready = 1'b0;
    logic [127:0] model_dat = '0;
    pend_t pq[$];
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    int n_acc = 0, n_pop = 0, n_res = 0, n_cv = 0;
    int out_before = 0, lvl_before = 0, last_acc_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm4_stream_bridge_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
    sm4_stream_bridge #(.DEPTH(DEPTH), .CW(CW)) dut (.CLK_i(clk), .RST_i(rst), .bus(bus));

    assign bus.CORE_READY_i = model_ready | inj;
    assign bus.CORE_DAT_i = inj ? inj_dat : model_dat;

    function automatic logic [127:0] core_f(input logic [127:0] d);
        return {d[63:0], d[127:64]} ^ {4{32'h9e3779b9}};
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // fixed-latency in-order core: result lands exactly lat cycles after CORE_VALID_o
    initial forever begin
        @(negedge clk);
        if (bus.CORE_VALID_o === 1'b1) pq.push_back(pend_t'{due: cyc + lat, d: core_f(bus.CORE_DAT_o)});
        @(posedge clk);
        #1;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            model_ready = 1'b1;
            model_dat = pq[0].d;
            void'(pq.pop_front());
        end else model_ready = 1'b0;
    end

    // abstract occupancy: outstanding = accepts - pops, stored = results - pops
    initial forever begin
        @(negedge clk);
        out_before = n_acc - n_pop;
        lvl_before = n_res - n_pop;
        if (bus.S_VALID_i === 1'b1 && bus.S_READY_o === 1'b1) begin
            exp_q.push_back(core_f(bus.S_DAT_i));
            n_acc++;
            last_acc_cyc = cyc;
        end
        if (bus.M_VALID_o === 1'b1 && bus.M_READY_i === 1'b1) begin
            got_q.push_back(bus.M_DAT_o);
            n_pop++;
        end
        if (bus.CORE_READY_i === 1'b1) n_res++;
        if (bus.CORE_VALID_o === 1'b1) n_cv++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_acc = 0; n_pop = 0; n_res = 0; n_cv = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && !(n_pop == n_acc && pq.size() == 0 && bus.M_VALID_o === 1'b0); i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.KEY_READY_i = 1'b1;
        bus.S_VALID_i = 1'b1;
        bus.M_READY_i = 1'b0;
        repeat (2) tick();
        mid();
        total += 7;
        if (bus.S_READY_o !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", bus.S_READY_o); end
        if (bus.CORE_VALID_o !== 1'b0) begin bad++; $display("FAIL rst_core_valid: got %b want 0", bus.CORE_VALID_o); end
        if (bus.M_VALID_o !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", bus.M_VALID_o); end
        if (bus.LEVEL_o !== '0) begin bad++; $display("FAIL rst_level: got %0d want 0", bus.LEVEL_o); end
        if (bus.ERR_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.ERR_o); end
        if (bus.CORE_DAT_o !== '0) begin bad++; $display("FAIL rst_core_dat: got %h want 0", bus.CORE_DAT_o); end
        if (bus.M_DAT_o !== '0) begin bad++; $display("FAIL rst_m_dat: got %h want 0", bus.M_DAT_o); end
        tick();
        rst = 1'b0;
        bus.S_VALID_i = 1'b0;
        bus.KEY_READY_i = 1'b0;
        clear_counts();
    endtask

    task automatic test_single();
        logic [127:0] blk, mdat;
        int ta, tcv, tmv;
        blk = 128'h0123456789abcdeffedcba9876543210;
        lat = 32;
        clear_counts();
        bus.KEY_READY_i = 1'b1;
        bus.M_READY_i = 1'b1;
        bus.S_DAT_i = blk;
        bus.S_VALID_i = 1'b1;
        mid();
        total++;
        if (bus.S_READY_o !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.S_READY_o); end
        ta = cyc;
        tick();
        bus.S_VALID_i = 1'b0;
        tcv = -1; tmv = -1; mdat = '0;
        for (int i = 0; i < 60; i++) begin
            mid();
            if (bus.CORE_VALID_o === 1'b1 && tcv < 0) tcv = cyc;
            if (bus.M_VALID_o === 1'b1 && tmv < 0) begin tmv = cyc; mdat = bus.M_DAT_o; end
            tick();
        end
        mid();
        total += 5;
        if (tcv != ta + 1) begin bad++; $display("FAIL single_core_valid_cycle: got %0d want %0d", tcv, ta + 1); end
        if (tmv != ta + 34) begin bad++; $display("FAIL single_m_valid_cycle: got %0d want %0d", tmv, ta + 34); end
        if (mdat !== core_f(blk)) begin bad++; $display("FAIL single_m_dat: got %h want %h", mdat, core_f(blk)); end
        if (bus.LEVEL_o !== '0) begin bad++; $display("FAIL single_level: got %0d want 0", bus.LEVEL_o); end
        if (n_cv != 1) begin bad++; $display("FAIL single_core_pulses: got %0d want 1", n_cv); end
        tick();
        lat = 4;
    endtask

    task automatic test_streaming();
        int sent, stalls, guard;
        logic took;
        clear_counts();
        sent = 0; stalls = 0; guard = 0;
        bus.KEY_READY_i = 1'b1;
        bus.M_READY_i = 1'b1;
        bus.S_DAT_i = rnd();
        bus.S_VALID_i = 1'b1;
        while (sent < 100 && guard < 400) begin
            guard++;
            mid();
            took = bus.S_READY_o === 1'b1;
            if (!took) stalls++; else sent++;
            total += 2;
            if (bus.S_READY_o !== (out_before < DEPTH)) begin bad++; $display("FAIL stream_credit: got %b want %b", bus.S_READY_o, out_before < DEPTH); end
            if (int'(bus.LEVEL_o) != lvl_before) begin bad++; $display("FAIL stream_level: got %0d want %0d", bus.LEVEL_o, lvl_before); end
            tick();
            if (sent == 100) bus.S_VALID_i = 1'b0; else if (took) bus.S_DAT_i = rnd();
        end
        wait_drain();
        total += 3;
        if (stalls != 0) begin bad++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
        if (n_acc != 100) begin bad++; $display("FAIL stream_accepts: got %0d want 100", n_acc); end
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic took;
        int guard;
        clear_counts();
        bus.KEY_READY_i = 1'b1;
        bus.M_READY_i = 1'b0;
        bus.S_DAT_i = rnd();
        bus.S_VALID_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            mid();
            took = bus.S_READY_o === 1'b1;
            tick();
            if (took) bus.S_DAT_i = rnd();
        end
        mid();
        total += 3;
        if (n_acc != DEPTH) begin bad++; $display("FAIL bp_accepts: got %0d want %0d", n_acc, DEPTH); end
        if (bus.S_READY_o !== 1'b0) begin bad++; $display("FAIL bp_s_ready: got %b want 0", bus.S_READY_o); end
        if (int'(bus.LEVEL_o) != DEPTH) begin bad++; $display("FAIL bp_level: got %0d want %0d", bus.LEVEL_o, DEPTH); end
        tick();
        bus.M_READY_i = 1'b1;
        guard = 0;
        while (n_acc < 2 * DEPTH && guard < 100) begin
            guard++;
            mid();
            took = bus.S_READY_o === 1'b1;
            tick();
            if (took) bus.S_DAT_i = rnd();
        end
        bus.S_VALID_i = 1'b0;
        wait_drain();
        total += 2;
        if (n_acc != 2 * DEPTH) begin bad++; $display("FAIL bp_resume: got %0d want %0d", n_acc, 2 * DEPTH); end
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_key_gating();
        int k;
        clear_counts();
        bus.KEY_READY_i = 1'b0;
        bus.M_READY_i = 1'b1;
        bus.S_DAT_i = rnd();
        bus.S_VALID_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mid();
            total++;
            if (bus.S_READY_o !== 1'b0) begin bad++; $display("FAIL key_low_ready: got %b want 0", bus.S_READY_o); end
            tick();
        end
        total++;
        if (n_cv != 0) begin bad++; $display("FAIL key_low_pulses: got %0d want 0", n_cv); end
        bus.KEY_READY_i = 1'b1;
        k = cyc;
        mid();
        total += 2;
        if (bus.S_READY_o !== 1'b1) begin bad++; $display("FAIL key_rise_ready: got %b want 1", bus.S_READY_o); end
        if (last_acc_cyc != k) begin bad++; $display("FAIL key_first_accept: got %0d want %0d", last_acc_cyc, k); end
        tick();
        bus.S_DAT_i = rnd();
        for (int i = 0; i < 3; i++) begin
            mid();
            tick();
            bus.S_DAT_i = rnd();
        end
        bus.KEY_READY_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        bus.S_VALID_i = 1'b0;
        wait_drain();
        total += 2;
        if (n_acc != 4) begin bad++; $display("FAIL key_fall_accepts: got %0d want 4", n_acc); end
        if (n_pop != 4) begin bad++; $display("FAIL key_fall_drain: got %0d want 4", n_pop); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL key_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        bus.KEY_READY_i = 1'b1;
    endtask

    task automatic test_full_wrap();
        logic took;
        int guard;
        clear_counts();
        bus.KEY_READY_i = 1'b1;
        bus.M_READY_i = 1'b0;
        bus.S_DAT_i = rnd();
        bus.S_VALID_i = 1'b1;
        for (int i = 0; i < 25; i++) begin
            mid();
            took = bus.S_READY_o === 1'b1;
            tick();
            if (took) bus.S_DAT_i = rnd();
        end
        mid();
        total++;
        if (int'(bus.LEVEL_o) != DEPTH) begin bad++; $display("FAIL wrap_full: got %0d want %0d", bus.LEVEL_o, DEPTH); end
        tick();
        guard = 0;
        while (n_acc < 3 * DEPTH && guard < 400) begin
            guard++;
            bus.M_READY_i = 1'($urandom_range(0, 1));
            mid();
            took = bus.S_READY_o === 1'b1;
            total += 3;
            if (int'(bus.LEVEL_o) != lvl_before) begin bad++; $display("FAIL wrap_level: got %0d want %0d", bus.LEVEL_o, lvl_before); end
            if (bus.S_READY_o !== (out_before < DEPTH)) begin bad++; $display("FAIL wrap_credit: got %b want %b", bus.S_READY_o, out_before < DEPTH); end
            if (bus.ERR_o !== 1'b0) begin bad++; $display("FAIL wrap_err: got %b want 0", bus.ERR_o); end
            tick();
            if (took) bus.S_DAT_i = rnd();
            if (n_acc == 3 * DEPTH) bus.S_VALID_i = 1'b0;
        end
        bus.S_VALID_i = 1'b0;
        bus.M_READY_i = 1'b1;
        wait_drain();
        total += 2;
        if (n_acc != 3 * DEPTH) begin bad++; $display("FAIL wrap_accepts: got %0d want %0d", n_acc, 3 * DEPTH); end
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_error();
        bus.KEY_READY_i = 1'b1;
        bus.M_READY_i = 1'b0;
        tick();
        inj_dat = rnd();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        mid();
`ifdef SM4_BRIDGE_ERRCHK_EN
        total += 2;
        if (bus.ERR_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.ERR_o); end
        if (bus.LEVEL_o !== '0) begin bad++; $display("FAIL err_level: got %0d want 0", bus.LEVEL_o); end
        repeat (5) tick();
        mid();
        total++;
        if (bus.ERR_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.ERR_o); end
        tick();
        rst = 1'b1;
        tick();
        mid();
        total++;
        if (bus.ERR_o !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", bus.ERR_o); end
        tick();
        rst = 1'b0;
`else
        total += 3;
        if (bus.ERR_o !== 1'b0) begin bad++; $display("FAIL err_tied: got %b want 0", bus.ERR_o); end
        if (int'(bus.LEVEL_o) != 1) begin bad++; $display("FAIL err_stored_level: got %0d want 1", bus.LEVEL_o); end
        if (bus.M_DAT_o !== inj_dat) begin bad++; $display("FAIL err_stored_dat: got %h want %h", bus.M_DAT_o, inj_dat); end
        tick();
        bus.M_READY_i = 1'b1;
        tick();
        mid();
        total++;
        if (bus.LEVEL_o !== '0) begin bad++; $display("FAIL err_drain_level: got %0d want 0", bus.LEVEL_o); end
`endif
    endtask

    initial begin
        bus.KEY_READY_i = 1'b0;
        bus.S_DAT_i = '0;
        bus.S_VALID_i = 1'b0;
        bus.M_READY_i = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_key_gating();
        test_full_wrap();
        test_reset();
        test_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
